// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and byte-enable constants for the memory stage
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] BE_HALF = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/mem_stage_byte_lane.sv
// rtl/mem_stage_byte_lane.sv - store byte replication / enables and load byte select
module mem_byte_lane
  import mem_stage_pkg::*;
(
  input  logic        byte_i,
  input  logic        lsb_i,
  input  logic [15:0] st_data_i,
  output logic [1:0]  be_o,
  output logic [15:0] wdata_o,
  input  logic        ld_byte_i,
  input  logic        ld_lsb_i,
  input  logic [15:0] rdata_i,
  output logic [15:0] ld_data_o
);

  always_comb begin
    be_o      = BE_HALF;
    wdata_o   = st_data_i;
    ld_data_o = rdata_i;
    if (byte_i) begin
      be_o    = lsb_i ? BE_HI : BE_LO;
      wdata_o = {st_data_i[7:0], st_data_i[7:0]};
    end
    if (ld_byte_i) begin
      ld_data_o = {8'h00, (ld_lsb_i ? rdata_i[15:8] : rdata_i[7:0])};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/ack data port and writeback bundle
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] alu_out_in,
  input  logic [15:0] regdata2_in,
  input  logic [3:0]  wreg_loc_in,
  input  logic        wreg_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        byte_in,
  input  logic        flush,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [14:0] dmem_addr,
  output logic [1:0]  dmem_be,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_loc,
  output logic        wb_en,
  output logic        err
);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        req_q, req_d, we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  loc_q, loc_d;
  logic        en_q, en_d, byte_q, byte_d, lsb_q, lsb_d;
  logic        wb_valid_q, wb_valid_d, wb_en_q, wb_en_d, err_q, err_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [3:0]  wb_loc_q, wb_loc_d;

  logic [1:0]  lane_be;
  logic [15:0] lane_wdata, lane_ld_data;
  logic        killed;

  mem_byte_lane u_lane (
    .byte_i    (byte_in),
    .lsb_i     (alu_out_in[0]),
    .st_data_i (regdata2_in),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .ld_byte_i (byte_q),
    .ld_lsb_i  (lsb_q),
    .rdata_i   (dmem_rdata),
    .ld_data_o (lane_ld_data)
  );

  // A flush arriving in the ack/abort cycle itself still kills the retirement.
  assign killed = kill_q | flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kill_d     = kill_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    loc_d      = loc_q;
    en_d       = en_q;
    byte_d     = byte_q;
    lsb_d      = lsb_q;
    wb_valid_d = 1'b0;
    wb_en_d    = 1'b0;
    err_d      = 1'b0;
    wb_data_d  = wb_data_q;
    wb_loc_d   = wb_loc_q;

    case (state_q)
      IDLE: begin
        if (valid_in && !flush) begin
          if (mem_read_in && mem_write_in) begin
            wb_valid_d = 1'b1;
            wb_data_d  = 16'h0000;
            wb_loc_d   = wreg_loc_in;
            err_d      = 1'b1;
          end else if (mem_read_in || mem_write_in) begin
            state_d = BUSY;
            cnt_d   = '0;
            kill_d  = 1'b0;
            req_d   = 1'b1;
            we_d    = mem_write_in;
            addr_d  = alu_out_in[15:1];
            be_d    = lane_be;
            wdata_d = lane_wdata;
            loc_d   = wreg_loc_in;
            en_d    = wreg_en_in;
            byte_d  = byte_in;
            lsb_d   = alu_out_in[0];
            err_d   = !byte_in && alu_out_in[0];
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_out_in;
            wb_loc_d   = wreg_loc_in;
            wb_en_d    = wreg_en_in;
          end
        end
      end
      BUSY: begin
        if (flush) kill_d = 1'b1;
        if (dmem_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          kill_d     = 1'b0;
          wb_valid_d = !killed;
          wb_en_d    = !killed && !we_q && en_q;
          wb_data_d  = we_q ? 16'h0000 : lane_ld_data;
          wb_loc_d   = loc_q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          kill_d     = 1'b0;
          wb_valid_d = !killed;
          wb_data_d  = 16'h0000;
          wb_loc_d   = loc_q;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      loc_q      <= '0;
      en_q       <= 1'b0;
      byte_q     <= 1'b0;
      lsb_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      err_q      <= 1'b0;
      wb_data_q  <= '0;
      wb_loc_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      loc_q      <= loc_d;
      en_q       <= en_d;
      byte_q     <= byte_d;
      lsb_q      <= lsb_d;
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      err_q      <= err_d;
      wb_data_q  <= wb_data_d;
      wb_loc_q   <= wb_loc_d;
    end
  end

  assign stall_out  = (state_q == BUSY);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_loc     = wb_loc_q;
  assign wb_en      = wb_en_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] alu_out_in = '0;
  logic [15:0] regdata2_in = '0;
  logic [3:0]  wreg_loc_in = '0;
  logic        wreg_en_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        byte_in = 1'b0;
  logic        flush = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        stall_out, dmem_req, dmem_we, wb_valid, wb_en, err;
  logic [14:0] dmem_addr;
  logic [1:0]  dmem_be;
  logic [15:0] dmem_wdata, wb_data;
  logic [3:0]  wb_loc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  loc;
    logic        en;
    logic        chk_data;
  } exp_t;
  exp_t exp_q[$];

  mem_stage #(.TIMEOUT(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_out_in(alu_out_in),
    .regdata2_in(regdata2_in), .wreg_loc_in(wreg_loc_in), .wreg_en_in(wreg_en_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .byte_in(byte_in),
    .flush(flush), .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_loc(wb_loc), .wb_en(wb_en), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: wb_valid=1 data=%h loc=%0d, no retirement expected", wb_data, wb_loc);
      end else begin
        e = exp_q.pop_front();
        if (wb_loc !== e.loc || wb_en !== e.en || (e.chk_data && wb_data !== e.data)) begin
          errors++;
          $display("FAIL wb_bundle: got data=%h loc=%0d en=%b, want data=%h loc=%0d en=%b",
                   wb_data, wb_loc, wb_en, e.data, e.loc, e.en);
        end
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic [3:0] l, input logic en, input logic cd);
    exp_t e;
    e.data = d; e.loc = l; e.en = en; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [15:0] alu, input logic [15:0] rd2, input logic [3:0] loc,
                       input logic en, input logic rd, input logic wr, input logic byt);
    valid_in = 1'b1; alu_out_in = alu; regdata2_in = rd2; wreg_loc_in = loc;
    wreg_en_in = en; mem_read_in = rd; mem_write_in = wr; byte_in = byt;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({stall_out, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_data, wb_loc, wb_en, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b stall=%b wb_valid=%b err=%b, want all zero", dmem_req, stall_out, wb_valid, err);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_half();
    push(16'h0000, 4'd0, 1'b0, 1'b0);
    issue(16'h0010, 16'hBEEF, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 15'h0008 ||
        dmem_be !== 2'b11 || dmem_wdata !== 16'hBEEF || err !== 1'b0) begin
      errors++;
      $display("FAIL sth_req: req=%b stall=%b we=%b addr=%h be=%b wdata=%h err=%b, want 1 1 1 0008 11 beef 0",
               dmem_req, stall_out, dmem_we, dmem_addr, dmem_be, dmem_wdata, err);
    end
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1 || dmem_addr !== 15'h0008 || dmem_wdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL sth_hold: req=%b stall=%b addr=%h wdata=%h, want 1 1 0008 beef", dmem_req, stall_out, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL sth_done: req=%b stall=%b wb_valid=%b, want 0 0 1", dmem_req, stall_out, wb_valid);
    end
  endtask

  task automatic test_ldrb_odd();
    push(16'h00A5, 4'd3, 1'b1, 1'b1);
    issue(16'h0021, 16'h0000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 2'b10 || dmem_addr !== 15'h0010) begin
      errors++;
      $display("FAIL ldrb_req: req=%b we=%b be=%b addr=%h, want 1 0 10 0010", dmem_req, dmem_we, dmem_be, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = 16'hA55A;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL ldrb_done: req=%b wb_valid=%b, want 0 1", dmem_req, wb_valid);
    end
  endtask

  task automatic test_strb_even();
    push(16'h0000, 4'd5, 1'b0, 1'b0);
    issue(16'h0030, 16'h1234, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (dmem_be !== 2'b01 || dmem_wdata !== 16'h3434 || dmem_addr !== 15'h0018 || dmem_we !== 1'b1) begin
      errors++;
      $display("FAIL strb_req: be=%b wdata=%h addr=%h we=%b, want 01 3434 0018 1", dmem_be, dmem_wdata, dmem_addr, dmem_we);
    end
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    push(16'h0001, 4'd1, 1'b1, 1'b1);
    push(16'h0002, 4'd2, 1'b1, 1'b1);
    valid_in = 1'b1; alu_out_in = 16'h0001; wreg_loc_in = 4'd1; wreg_en_in = 1'b1;
    @(posedge clk); #1;
    alu_out_in = 16'h0002; wreg_loc_in = 4'd2;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || wb_data !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_first: req=%b stall=%b wb_data=%h, want 0 0 0001", dmem_req, stall_out, wb_data);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || wb_data !== 16'h0002) begin
      errors++;
      $display("FAIL b2b_second: req=%b stall=%b wb_data=%h, want 0 0 0002", dmem_req, stall_out, wb_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    push(16'h1357, 4'd2, 1'b1, 1'b1);
    issue(16'h0011, 16'h0000, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || dmem_req !== 1'b1 || dmem_addr !== 15'h0008 || dmem_be !== 2'b11) begin
      errors++;
      $display("FAIL misalign: err=%b req=%b addr=%h be=%b, want 1 1 0008 11", err, dmem_req, dmem_addr, dmem_be);
    end
    dmem_ack = 1'b1; dmem_rdata = 16'h1357;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%b after misaligned retire, want 0", err);
    end
    push(16'h0000, 4'd6, 1'b0, 1'b0);
    issue(16'h0040, 16'h0000, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || dmem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL rw_conflict: err=%b req=%b stall=%b wb_valid=%b, want 1 0 0 1", err, dmem_req, stall_out, wb_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int n = 0;
    push(16'h0000, 4'd7, 1'b0, 1'b0);
    issue(16'h0040, 16'h0000, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (dmem_req !== 1'b1) break;
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 8 || err !== 1'b1 || wb_valid !== 1'b1 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout: req_cycles=%0d err=%b wb_valid=%b stall=%b, want 8 1 1 0", n, err, wb_valid, stall_out);
    end
    push(16'h00AB, 4'd8, 1'b1, 1'b1);
    issue(16'h00AB, 16'h0000, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h00AB || err !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: wb_valid=%b wb_data=%h err=%b, want 1 00ab 0", wb_valid, wb_data, err);
    end
  endtask

  task automatic test_flush_reset();
    valid_in = 1'b1; flush = 1'b1; alu_out_in = 16'h0077; wreg_en_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: wb_valid=%b req=%b stall=%b, want 0 0 0", wb_valid, dmem_req, stall_out);
    end
    issue(16'h0050, 16'h0000, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || wb_en !== 1'b0 || dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: wb_valid=%b wb_en=%b req=%b stall=%b, want 0 0 0 0", wb_valid, wb_en, dmem_req, stall_out);
    end
    issue(16'h0060, 16'hCAFE, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_out, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_data, wb_loc, wb_en, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: req=%b stall=%b we=%b addr=%h wdata=%h, want all zero", dmem_req, stall_out, dmem_we, dmem_addr, dmem_wdata);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_store_half();
    test_ldrb_odd();
    test_strb_even();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_flush_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d retirements missing, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipelined core. Sits directly downstream of the execute stage and consumes its registered result:
- the ALU result, used as the byte address or as the pass-through data;
- the store data;
- the destination register and its write enable;
- the memory read/write/byte controls.

It drives a request/acknowledge data-memory port and stalls the pipeline while a transfer is outstanding. It delivers one registered writeback bundle per retired instruction to the register-file write stage.

## Interface
Parameters:
- TIMEOUT, 16: max cycles a request waits for dmem_ack before abort (≥2).
- CNT_W, 5: width of the timeout counter (2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-low
- valid_in  in  1  EX bundle valid this cycle
- alu_out_in  in  16  byte address (mem ops) or result (non-mem)
- regdata2_in  in  16  store data
- wreg_loc_in  in  4  destination register
- wreg_en_in  in  1  destination write enable
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- byte_in  in  1  byte access (ldrb/strb), else halfword
- flush  in  1  kill the instruction presented/in flight (branch flush)
- stall_out  out  1  upstream must hold its bundle
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  15  halfword address = alu_out_in[15:1]
- dmem_be  out  2  byte enables, bit0 = bits[7:0]
- dmem_wdata  out  16  write data
- dmem_ack  in  1  transfer complete (rdata valid for reads)
- dmem_rdata  in  16  read data
- wb_valid  out  1  writeback bundle valid
- wb_data  out  16  writeback value
- wb_loc  out  4  writeback register
- wb_en  out  1  writeback enable
- err  out  1  one-cycle pulse: misaligned, read+write conflict, or timeout

## Operation
- States:
  - IDLE: accepts bundles.
  - BUSY: request outstanding.
- Accept when state = IDLE and valid_in = 1.
- Non-mem bundle (read = write = 0):
  - registered to wb_* next cycle: wb_data = alu_out_in, wb_en = wreg_en_in.
  - no request issued.
- Mem bundle:
  - dmem_* registered next cycle with dmem_req = 1; state → BUSY; counter cleared.
  - Request fields are held stable until ack or abort.
- Address mapping:
  - Halfword: be = 11; wdata = regdata2_in.
  - Byte with alu_out_in[0] = 0: be = 01. Byte with alu_out_in[0] = 1: be = 10.
  - Byte stores: wdata = {regdata2_in[7:0], regdata2_in[7:0]}.
- Loads: wb_data = rdata (halfword), or the selected byte zero-extended. Loads write back with wb_en = wreg_en_in. Stores retire with wb_en = 0.
- Error cases (each gives an err pulse):
  - Halfword with alu_out_in[0] = 1: access proceeds at alu_out_in[15:1].
  - read & write both set: no request; retire immediately with wb_en = 0.
- Timeout: in BUSY the counter increments each cycle without ack. When it reaches TIMEOUT-1 with no ack:
  - dmem_req drops; state → IDLE;
  - retire with wb_en = 0; err pulse.
- Flush:
  - In IDLE, a flush in the same cycle as valid_in drops the bundle: nothing issued, wb_valid = 0.
  - In BUSY, flush sets a kill flag. The transfer still completes, but it retires with wb_valid = 0 and wb_en = 0.
- Reset: state IDLE, counter 0, kill flag 0. All outputs are 0 (stall_out, dmem_*, wb_*, err).

## Timing
- Bundle accepted at edge N.
- Non-mem: wb_* valid in cycle N+1.
- Mem request: dmem_req is high from cycle N+1.
- dmem_ack is sampled each edge while dmem_req = 1; the earliest ack is in cycle N+1.
- Ack sampled at edge M:
  - dmem_req = 0 and state = IDLE in cycle M+1;
  - wb_* valid in cycle M+1;
  - a new bundle can be accepted at edge M+1.
- stall_out = (state == BUSY), a Moore output. It covers every cycle dmem_req is high.
- wb_valid and err are single-cycle pulses per retirement.
- Async reset mid-BUSY: dmem_req is deasserted immediately, without waiting for a clock. The in-flight instruction is lost.

## Structure
- Package mem_stage_pkg holds:
  - state enum {IDLE, BUSY};
  - byte-enable constants BE_HALF = 2'b11, BE_LO = 2'b01, BE_HI = 2'b10.
- Sub-module mem_byte_lane (combinational): store replication and be generation; load byte select and zero-extension. Shared with any future halfword/byte unit.

## Test plan
- Store halfword:
  - Stimulus: alu_out 0x0010, regdata2 0xBEEF, ack 2 cycles after req.
  - Response: addr 0x0008, be 11, wdata 0xBEEF, req high 2 cycles, stall_out high 2 cycles, wb_valid = 1, wb_en = 0.
- ldrb odd:
  - Stimulus: alu_out 0x0021, rdata 0xA55A, ack in first req cycle, wreg_loc 3.
  - Response: wb_data 0x00A5, wb_loc 3, wb_en 1.
- strb even:
  - Stimulus: alu_out 0x0030, regdata2 0x1234.
  - Response: be 01, wdata 0x3434, addr 0x0018.
- Back-to-back non-mem:
  - Stimulus: results 0x0001, 0x0002 on consecutive cycles.
  - Response: wb_data 0x0001 then 0x0002 on consecutive cycles, dmem_req never high, stall_out 0.
- Timeout:
  - Stimulus: TIMEOUT = 8, load with ack tied 0.
  - Response: req high exactly 8 cycles, then err pulse, wb_valid = 1 with wb_en = 0, next bundle accepted.
- Flush and reset:
  - Stimulus: flush in the 2nd BUSY cycle, ack in the 3rd.
  - Response: wb_valid stays 0.
  - Then: rst low mid-BUSY gives dmem_req = 0 asynchronously and all outputs 0.
